tanh_layer_ctrl: RTL and testbench

Sequencer for the tanh layer datapath. Accepts forward-pass and backward-pass requests for a batch, arbitrates between them, and issues run_forward, run_backward and load_backward one sample at a time. It drives the per-sample state indices and waits for each valid before stepping to the next sample. A watchdog aborts a pass whose datapath never responds.

---
 rtl/tanh_layer_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_tanh_layer_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_layer_ctrl.sv
// tanh_layer_ctrl: arbitrates forward/backward batch passes and steps the tanh datapath sample by sample.
// Optional pass cycle counter on perf_cycles is built when TANH_CTRL_PERF_EN is defined.
//
// state    | meaning
// S_IDLE   | no pass running; picks up requests, forward first
// S_F_RUN  | run_forward pulse for sample idx
// S_F_WAIT | waiting for valid_forward, watchdog counting
// S_B_LOAD | load_backward pulse for sample idx
// S_B_RUN  | run_backward pulse for sample idx
// S_B_WAIT | waiting for valid_backward, watchdog counting
module tanh_layer_ctrl #(
  parameter int STATE_LEN = 4,
  parameter int BATCH     = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_forward,
  input  logic                 start_backward,
  input  logic                 valid_forward,
  input  logic                 valid_backward,
  output logic                 run_forward,
  output logic                 run_backward,
  output logic                 load_backward,
  output logic [STATE_LEN-1:0] state_forward,
  output logic [STATE_LEN-1:0] state_backward,
  output logic                 busy,
  output logic                 done_forward,
  output logic                 done_backward,
  output logic                 error
`ifdef TANH_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_F_RUN, S_F_WAIT, S_B_LOAD, S_B_RUN, S_B_WAIT
  } state_t;

  localparam logic [STATE_LEN-1:0] LAST_IDX = STATE_LEN'(BATCH - 1);
  localparam logic [STATE_LEN-1:0] IDX_ONE  = STATE_LEN'(1);
  localparam logic [7:0]           WD_LIMIT = 8'(TIMEOUT);

  state_t               state_q, state_d;
  logic [STATE_LEN-1:0] idx_q, idx_d;
  logic                 pend_f_q, pend_f_d;
  logic                 pend_b_q, pend_b_d;
  logic [7:0]           wd_q, wd_d, wd_inc;
  logic                 error_d;
  logic                 done_f_d, done_b_d;
  logic                 wait_valid;

  logic                 run_f_d, run_b_d, load_b_d, busy_d;
  logic [STATE_LEN-1:0] state_f_d, state_b_d;

  assign wd_inc     = wd_q + 8'd1;
  assign wait_valid = (state_q == S_F_WAIT) ? valid_forward : valid_backward;

  // Next-state, index, pending and watchdog logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_f_d = pend_f_q;
    pend_b_d = pend_b_q;
    wd_d     = wd_q;
    error_d  = error;
    done_f_d = 1'b0;
    done_b_d = 1'b0;

    if (state_q != S_IDLE) begin
      if (start_forward)  pend_f_d = 1'b1;
      if (start_backward) pend_b_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_forward || pend_f_q) begin
          state_d  = S_F_RUN;
          idx_d    = '0;
          pend_f_d = 1'b0;
          pend_b_d = pend_b_q | start_backward;
        end else if (start_backward || pend_b_q) begin
          state_d  = S_B_LOAD;
          idx_d    = '0;
          pend_b_d = 1'b0;
        end
      end
      S_F_RUN: begin
        state_d = S_F_WAIT;
        wd_d    = '0;
      end
      S_B_LOAD: begin
        state_d = S_B_RUN;
      end
      S_B_RUN: begin
        state_d = S_B_WAIT;
        wd_d    = '0;
      end
      S_F_WAIT, S_B_WAIT: begin
        if (wait_valid) begin
          if (idx_q == LAST_IDX) begin
            state_d  = S_IDLE;
            done_f_d = (state_q == S_F_WAIT);
            done_b_d = (state_q == S_B_WAIT);
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = (state_q == S_F_WAIT) ? S_F_RUN : S_B_LOAD;
          end
        end else if (wd_inc == WD_LIMIT) begin
          // Watchdog abort drops queued work too; the host must re-request.
          state_d  = S_IDLE;
          error_d  = 1'b1;
          pend_f_d = 1'b0;
          pend_b_d = 1'b0;
        end else begin
          wd_d = wd_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    run_f_d   = (state_d == S_F_RUN);
    run_b_d   = (state_d == S_B_RUN);
    load_b_d  = (state_d == S_B_LOAD);
    busy_d    = (state_d != S_IDLE);
    state_f_d = ((state_d == S_F_RUN) || (state_d == S_F_WAIT)) ? idx_d : '0;
    state_b_d = ((state_d == S_B_LOAD) || (state_d == S_B_RUN) || (state_d == S_B_WAIT))
                ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      pend_f_q       <= 1'b0;
      pend_b_q       <= 1'b0;
      wd_q           <= '0;
      error          <= 1'b0;
      done_forward   <= 1'b0;
      done_backward  <= 1'b0;
      run_forward    <= 1'b0;
      run_backward   <= 1'b0;
      load_backward  <= 1'b0;
      busy           <= 1'b0;
      state_forward  <= '0;
      state_backward <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pend_f_q       <= pend_f_d;
      pend_b_q       <= pend_b_d;
      wd_q           <= wd_d;
      error          <= error_d;
      done_forward   <= done_f_d;
      done_backward  <= done_b_d;
      run_forward    <= run_f_d;
      run_backward   <= run_b_d;
      load_backward  <= load_b_d;
      busy           <= busy_d;
      state_forward  <= state_f_d;
      state_backward <= state_b_d;
    end
  end

`ifdef TANH_CTRL_PERF_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] perf_total;

  assign perf_total = (perf_cnt_q == 32'hFFFF_FFFF) ? perf_cnt_q : perf_cnt_q + 32'd1;

  // perf_cnt_q counts busy cycles of the live pass; perf_cycles only moves on a done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt_q  <= '0;
      perf_cycles <= '0;
    end else begin
      if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
        perf_cnt_q <= 32'd1;
      end else if (state_q != S_IDLE) begin
        perf_cnt_q <= perf_total;
      end
      if (done_f_d || done_b_d) begin
        perf_cycles <= perf_total;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tanh_layer_ctrl.sv
// Scoreboard bench for tanh_layer_ctrl: a pass-level model predicts each pulse and its cycle,
// a monitor pops and compares whenever the DUT shows an event.
module tb_tanh_layer_ctrl;
  localparam int SL      = 4;
  localparam int BATCH   = 4;
  localparam int TIMEOUT = 16;

  localparam int K_RUNF  = 0;
  localparam int K_RUNB  = 1;
  localparam int K_LOAD  = 2;
  localparam int K_DONEF = 3;
  localparam int K_DONEB = 4;
  localparam int K_ERR   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_forward = 1'b0, start_backward = 1'b0;
  logic valid_forward = 1'b0, valid_backward = 1'b0;
  logic run_forward, run_backward, load_backward, busy;
  logic done_forward, done_backward, error;
  logic [SL-1:0] state_forward, state_backward;
`ifdef TANH_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int idx;
    int cyc;
    int perf;
  } ev_t;
  ev_t exp_q[$];

  bit pend_f_m = 1'b0, pend_b_m = 1'b0;
  int opt_abort = -1, opt_rst = -1, opt_d = 0, opt_inj_f = 0, opt_inj_b = 0;
  logic err_prev = 1'b0;

  tanh_layer_ctrl #(.STATE_LEN(SL), .BATCH(BATCH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_forward(start_forward), .start_backward(start_backward),
    .valid_forward(valid_forward), .valid_backward(valid_backward),
    .run_forward(run_forward), .run_backward(run_backward), .load_backward(load_backward),
    .state_forward(state_forward), .state_backward(state_backward),
    .busy(busy), .done_forward(done_forward), .done_backward(done_backward),
    .error(error)
`ifdef TANH_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_ev(input int k, input int idx, input int c, input int p);
    ev_t e;
    e.kind = k; e.idx = idx; e.cyc = c; e.perf = p;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int k, input int idx);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d idx %0d at cycle %0d, nothing expected", k, idx, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_idx", idx, e.idx);
      if (k == K_DONEF || k == K_DONEB || k == K_ERR) chk("busy_after_pass", {31'd0, busy}, 0);
      else chk("busy_during_pass", {31'd0, busy}, 1);
`ifdef TANH_CTRL_PERF_EN
      if (k == K_DONEF || k == K_DONEB) chk("perf_cycles", perf_cycles, e.perf);
`endif
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (load_backward) check_event(K_LOAD, int'(state_backward));
    if (run_forward) begin
      check_event(K_RUNF, int'(state_forward));
      chk("bwd_idx_idle", {28'd0, state_backward}, 0);
    end
    if (run_backward) begin
      check_event(K_RUNB, int'(state_backward));
      chk("fwd_idx_idle", {28'd0, state_forward}, 0);
    end
    if (done_forward) check_event(K_DONEF, 0);
    if (done_backward) check_event(K_DONEB, 0);
    if (error && !err_prev) check_event(K_ERR, 0);
    err_prev = error;
  end

  task automatic wait_until(input int c);
    if (cyc > c) begin
      checks++;
      errors++;
      $display("FAIL schedule: now cycle %0d, wanted %0d", cyc, c);
    end
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clear_inputs();
    valid_forward = 1'b0; valid_backward = 1'b0;
    start_forward = 1'b0; start_backward = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {17'd0, run_forward, run_backward, load_backward, busy, done_forward,
               done_backward, error, state_forward, state_backward}, 0);
  endtask

  // Plays one pass launched from the IDLE cycle launch_c; end_c is the next IDLE cycle.
  task automatic run_pass(input bit fwd, input int launch_c, output int end_c);
    int ab = opt_abort, rs = opt_rst, fd = opt_d, inf = opt_inj_f, inb = opt_inj_b;
    int t, r, d, last;
    bit spur, vld;
    opt_abort = -1; opt_rst = -1; opt_d = 0; opt_inj_f = 0; opt_inj_b = 0;
    t = launch_c + 1;
    for (int s = 0; s < BATCH; s++) begin
      if (!fwd) push_ev(K_LOAD, s, t, 0);
      r = fwd ? t : t + 1;
      push_ev(fwd ? K_RUNF : K_RUNB, s, r, 0);
      if (s == ab) push_ev(K_ERR, 0, r + TIMEOUT + 1, 0);
      d = (fd > 0) ? fd : (($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(1, 6)));
      spur = ($urandom_range(0, 3) == 0);
      wait_until(t);
      clear_inputs();
      if (s == rs) begin
        wait_until(r + 1);
        rst_n = 1'b0;
        wait_until(r + 2);
        rst_n = 1'b1;
        pend_f_m = 1'b0; pend_b_m = 1'b0;
        check_all_zero("outputs_after_midpass_reset");
        end_c = r + 2;
        return;
      end
      last = (s == ab) ? r + TIMEOUT : r + d;
      for (int c = r; c <= last; c++) begin
        wait_until(c);
        chk("busy_in_pass", {31'd0, busy}, 1);
        chk("sample_idx", fwd ? {28'd0, state_forward} : {28'd0, state_backward}, s);
        vld = (c == r && spur) || (c == r + d && s != ab);
        if (fwd) valid_forward = vld; else valid_backward = vld;
        start_forward  = (c == r + 1) && inf[s];
        start_backward = (c == r + 1) && inb[s];
        if (start_forward)  pend_f_m = 1'b1;
        if (start_backward) pend_b_m = 1'b1;
      end
      if (s == ab) begin
        pend_f_m = 1'b0; pend_b_m = 1'b0;
        end_c = r + TIMEOUT + 1;
        wait_until(end_c);
        clear_inputs();
        return;
      end
      t = r + d + 1;
    end
    push_ev(fwd ? K_DONEF : K_DONEB, 0, t, t - launch_c);
    end_c = t;
    wait_until(t);
    clear_inputs();
  endtask

  // Launch whatever is pending from IDLE cycle c, forward first, until nothing is left.
  task automatic serve(input int c);
    int e;
    while (pend_f_m || pend_b_m) begin
      if (pend_f_m) begin
        pend_f_m = 1'b0;
        run_pass(1'b1, c, e);
      end else begin
        pend_b_m = 1'b0;
        run_pass(1'b0, c, e);
      end
      c = e;
    end
  endtask

  task automatic issue(input int c, input bit sf, input bit sb);
    wait_until(c);
    start_forward = sf;
    start_backward = sb;
    if (sf) pend_f_m = 1'b1;
    if (sb) pend_b_m = 1'b1;
    serve(c);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: bench did not finish by cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bit sf, sb;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    wait_until(cyc + 2);

    // Fixed 3-cycle datapath latency, forward only
    opt_d = 3;
    issue(cyc + 1, 1'b1, 1'b0);
    wait_until(cyc + 2);

    // Simultaneous requests: forward first, backward after one IDLE cycle
    issue(cyc + 1, 1'b1, 1'b1);
    wait_until(cyc + 3);

    // Two repeat forward starts while running collapse into one extra pass
    opt_inj_f = 'b0110;
    issue(cyc + 1, 1'b1, 1'b0);
    wait_until(cyc + 2);

    // Watchdog abort at sample 1 with a backward request queued, then a normal pass
    opt_abort = 1;
    opt_inj_b = 'b0001;
    issue(cyc + 1, 1'b1, 1'b0);
    chk("error_after_abort", {31'd0, error}, 1);
    wait_until(cyc + 3);
    chk("no_relaunch_after_abort", {31'd0, busy}, 0);
    issue(cyc + 1, 1'b1, 1'b0);
    chk("error_sticky", {31'd0, error}, 1);
    wait_until(cyc + 2);

    // Reset during B_WAIT of sample 2
    opt_rst = 2;
    issue(cyc + 1, 1'b0, 1'b1);
    wait_until(cyc + 20);
    chk("idle_after_reset", {31'd0, busy}, 0);

    // Randomized traffic
    for (int i = 0; i < 14; i++) begin
      sf = 1'($urandom_range(0, 1));
      sb = sf ? 1'($urandom_range(0, 1)) : 1'b1;
      opt_inj_f = int'($urandom_range(0, 15));
      opt_inj_b = int'($urandom_range(0, 15));
      opt_abort = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BATCH - 1)) : -1;
      issue(cyc + int'($urandom_range(0, 3)), sf, sb);
    end

    wait_until(cyc + 6);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_idle", {31'd0, busy}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
